ok_dram64x8_reader: RTL

Read-side controller for the 64x8 dual-port distributed-RAM buffer. The writer owns the RAM write port and publishes its write pointer. This block owns the asynchronous read port (addrB/doutB). It drains stored bytes in order into a registered valid/ready stream, returns its read pointer so the writer can compute full, and reports occupancy. Writer, RAM and reader share one clock.

---
 rtl/ok_dram64x8_reader_if.sv | 21 ++
 rtl/ok_dram64x8_reader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ok_dram64x8_reader_if.sv
// Byte stream carrying drained RAM data from the reader to its consumer.
// The master drives data/valid, the slave returns ready.
interface ok_dram64x8_reader_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/ok_dram64x8_reader.sv
// Read-side controller for the 64x8 distributed-RAM buffer: drains bytes in
// order into a registered valid/ready stream and reports occupancy.
module ok_dram64x8_reader #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int LOW_MARK = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [AW:0]          i_wr_ptr,
    output logic [AW-1:0]        o_ram_addr,
    input  logic [DW-1:0]        i_ram_dout,
    output logic [AW:0]          o_rd_ptr,
    ok_dram64x8_reader_if.master m_axis,
    input  logic                 i_flush,
    output logic [AW+1:0]        o_level,
    output logic                 o_empty,
    output logic                 o_almost_empty,
    output logic                 o_ptr_err
);

    localparam logic [AW:0]   DEPTH      = (AW+1)'(1 << AW);
    localparam logic [AW+1:0] LOW_MARK_W = (AW+2)'(LOW_MARK);

    // The output register's occupancy is the whole state.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_rd_ptr_nxt;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_nxt;
    logic [AW+1:0]   r_level;
    logic [AW+1:0]   w_level_nxt;
    logic            r_empty;
    logic            r_almost_empty;
    logic            r_ptr_err;
    logic [AW:0]     w_avail;
    logic [AW:0]     w_avail_nxt;
    logic            w_avail_bad;
    logic            w_load;

    assign w_avail     = i_wr_ptr - r_rd_ptr;
    assign w_avail_bad = (w_avail > DEPTH);
    assign w_load      = (w_avail != '0) && ((r_state == S_EMPTY) || m_axis.ready)
                         && !i_flush && !r_ptr_err;

    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_data_nxt   = r_data;

        unique case (r_state)
            S_EMPTY: if (w_load) w_state_nxt = S_HOLD;
            S_HOLD:  if (!w_load && m_axis.ready) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase

        if (w_load) begin
            w_data_nxt   = i_ram_dout;
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end

        // Flush discards RAM contents up to the pre-edge write pointer; a byte
        // written on this same edge lands beyond it and survives.
        if (i_flush) begin
            w_state_nxt  = S_EMPTY;
            w_rd_ptr_nxt = i_wr_ptr;
        end
    end

    assign w_avail_nxt = i_wr_ptr - w_rd_ptr_nxt;
    assign w_level_nxt = {1'b0, w_avail_nxt}
                         + {{(AW+1){1'b0}}, (w_state_nxt == S_HOLD)};

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_EMPTY;
            r_rd_ptr       <= '0;
            r_data         <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_ptr_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_data         <= w_data_nxt;
            r_level        <= w_level_nxt;
            r_empty        <= (w_level_nxt == '0);
            r_almost_empty <= (w_level_nxt <= LOW_MARK_W);
            r_ptr_err      <= r_ptr_err | w_avail_bad;
        end
    end

    assign o_ram_addr     = r_rd_ptr[AW-1:0];
    assign o_rd_ptr       = r_rd_ptr;
    assign m_axis.data    = r_data;
    assign m_axis.valid   = (r_state == S_HOLD);
    assign o_level        = r_level;
    assign o_empty        = r_empty;
    assign o_almost_empty = r_almost_empty;
    assign o_ptr_err      = r_ptr_err;

    // A stalled byte must neither change nor vanish.
    a_stall_stable: assert property (
        @(posedge i_clk)
        (m_axis.valid && !m_axis.ready && !i_flush && !i_reset)
        |=> (m_axis.valid && $stable(m_axis.data))
    );

endmodule
